// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, frame shift, ACK check.
// Define PS2_TX_GLITCH_FILTER_EN to debounce the PS/2 clock before edge detection.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_lvl, clk_prev, fall, data_s;
  logic [8:0]      frame;
  logic            data_drv;
  logic [3:0]      bit_cnt;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   to_cnt;
  logic            err;
  logic            to_hit, on_line, accept;

  // Two-flop synchronisers; idle line is high so reset to 1.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign data_s = data_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [FILTER_LEN-1:0] flt;

  // Level only moves after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flt     <= '1;
      clk_lvl <= 1'b1;
    end else begin
      flt <= {flt[FILTER_LEN-2:0], clk_sync[1]};
      if (&flt)
        clk_lvl <= 1'b1;
      else if (~|flt)
        clk_lvl <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = |FILTER_LEN;
  assign clk_lvl    = clk_sync[1];
`endif

  // Edge detector on the (optionally filtered) clock level.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) clk_prev <= 1'b1;
    else       clk_prev <= clk_lvl;
  end

  assign fall    = clk_prev & ~clk_lvl;
  assign on_line = (state == S_SHIFT) || (state == S_ACK) ||
                   (state == S_WAIT);
  assign to_hit  = on_line && (to_cnt >= TW'(TIMEOUT_CYCLES));
  assign accept  = (state == S_IDLE) && tx_start;

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and pad/handshake outputs.
  always_comb begin
    state_nx    = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (tx_start) state_nx = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1))
          state_nx = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_nx    = S_SHIFT;
      end
      S_SHIFT: begin
        ps2_data_oe = data_drv;
        if (fall && bit_cnt == 4'd9) state_nx = S_ACK;
      end
      S_ACK: begin
        if (fall) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (clk_lvl && data_s) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (to_hit) begin
      ps2_data_oe = 1'b0;
      state_nx    = S_DONE;
    end
  end

  // Frame shifter, counters and error flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame    <= '0;
      data_drv <= 1'b0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        frame   <= {1'b1, ~^tx_data, tx_data};
        err     <= 1'b0;
        inh_cnt <= '0;
        bit_cnt <= '0;
      end
      if (state == S_INHIBIT)
        inh_cnt <= inh_cnt + IW'(1);
      if (state == S_REQ) begin
        data_drv <= 1'b1;
        bit_cnt  <= '0;
      end
      if (state == S_SHIFT && fall) begin
        data_drv <= ~frame[0];
        frame    <= {1'b0, frame[8:1]};
        if (bit_cnt != 4'd9) bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == S_ACK && fall && data_s)
        err <= 1'b1;
      if (fall || state == S_REQ)
        to_cnt <= '0;
      else if (on_line && to_cnt < TW'(TIMEOUT_CYCLES))
        to_cnt <= to_cnt + TW'(1);
      if (to_hit)
        err <= 1'b1;
      if (state == S_DONE || state == S_IDLE)
        data_drv <= 1'b0;
    end
  end

  assign ack_err = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and each frame is compared with the byte/parity/stop expected from the command byte.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk), .clrn(clrn),
    .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [9:0] rx_vec;
  int         rx_n;
  int         last_fall;
  int         r_inh, r_req, r_cyc;
  logic       r_shift_ok, r_got, r_ae, r_bz, r_coe, r_doe, r_done2, r_bz2;

  // Expected wire frame: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] model(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    r_inh = 0;
    r_req = 0;
    while (ps2_clk_oe && !ps2_data_oe && r_inh < 1000) begin
      r_inh++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && r_req < 1000) begin
      r_req++;
      @(negedge clk);
    end
    r_shift_ok = !ps2_clk_oe && ps2_data_oe && (ps2_data_i == 1'b0);
  endtask

  task automatic device(input int nf, input bit ack, input bit glitch);
    rx_vec = '0;
    rx_n   = 0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= nf; i++) begin
      dev_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) begin
        rx_vec[i-1] = ps2_data_i;
        rx_n++;
      end
      if (i < nf) begin
        if (glitch && i == 3) begin
          repeat (5) @(negedge clk);
          dev_clk = 1'b0;
          repeat (3) @(negedge clk);
          dev_clk = 1'b1;
          repeat (HALF - 8) @(negedge clk);
        end else if (i == 10 && ack) begin
          repeat (HALF / 2) @(negedge clk);
          dev_data = 1'b0;
          repeat (HALF - HALF / 2) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done();
    r_got = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (done) begin
        r_got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    r_cyc = cyc;
    r_ae  = ack_err;
    r_bz  = busy;
    r_coe = ps2_clk_oe;
    r_doe = ps2_data_oe;
  endtask

  task automatic run_xfer(input logic [7:0] b, input int nf,
                          input bit ack, input bit glitch);
    send_start(b);
    device(nf, ack, glitch);
    wait_done();
    @(negedge clk);
    r_done2 = done;
    r_bz2   = busy;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_hold got=%b exp=00000",
               {ps2_clk_oe, ps2_data_oe, busy, done, ack_err});
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_release got=%b exp=00000",
               {ps2_clk_oe, ps2_data_oe, busy, done, ack_err});
    end
  endtask

  task automatic test_basic();
    run_xfer(8'hED, 11, 1'b1, 1'b0);
    tests++;
    if (r_inh !== INH) begin
      fails++;
      $display("FAIL basic_inhibit got=%0d exp=%0d", r_inh, INH);
    end
    tests++;
    if (r_req !== 1) begin
      fails++;
      $display("FAIL basic_req got=%0d exp=1", r_req);
    end
    tests++;
    if (r_shift_ok !== 1'b1) begin
      fails++;
      $display("FAIL basic_start_bit got=%b exp=1", r_shift_ok);
    end
    tests++;
    if (rx_vec !== 10'b11_1110_1101) begin
      fails++;
      $display("FAIL basic_frame got=%b exp=%b", rx_vec, 10'b11_1110_1101);
    end
    tests++;
    if ({r_got, r_ae, r_bz} !== 3'b100) begin
      fails++;
      $display("FAIL basic_done got=%b exp=100", {r_got, r_ae, r_bz});
    end
    tests++;
    if ({r_done2, r_bz2} !== 2'b00) begin
      fails++;
      $display("FAIL basic_after got=%b exp=00", {r_done2, r_bz2});
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [6];
    logic       par_exp [3];
    bytes[0] = 8'h07; par_exp[0] = 1'b0;
    bytes[1] = 8'hFF; par_exp[1] = 1'b1;
    bytes[2] = 8'h00; par_exp[2] = 1'b1;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      run_xfer(bytes[i], 11, 1'b1, 1'b0);
      if (i < 3) begin
        tests++;
        if (rx_vec[8] !== par_exp[i]) begin
          fails++;
          $display("FAIL parity_%0h got=%b exp=%b", bytes[i], rx_vec[8], par_exp[i]);
        end
      end
      tests++;
      if (rx_vec !== model(bytes[i]) || r_ae !== 1'b0 || r_got !== 1'b1) begin
        fails++;
        $display("FAIL frame_%0h got=%b ae=%b done=%b exp=%b ae=0 done=1",
                 bytes[i], rx_vec, r_ae, r_got, model(bytes[i]));
      end
    end
  endtask

  task automatic test_no_ack();
    logic [7:0] b;
    b = 8'($urandom);
    run_xfer(b, 11, 1'b0, 1'b0);
    tests++;
    if (rx_vec !== model(b)) begin
      fails++;
      $display("FAIL noack_frame got=%b exp=%b", rx_vec, model(b));
    end
    tests++;
    if ({r_got, r_ae, r_coe, r_doe} !== 4'b1100) begin
      fails++;
      $display("FAIL noack_err got=%b exp=1100", {r_got, r_ae, r_coe, r_doe});
    end
  endtask

  task automatic test_timeout();
    int dly;
    run_xfer(8'hA5, 4, 1'b0, 1'b0);
    dly = r_cyc - last_fall;
    tests++;
    if ({r_got, r_ae, r_coe, r_doe} !== 4'b1100) begin
      fails++;
      $display("FAIL timeout_err got=%b exp=1100", {r_got, r_ae, r_coe, r_doe});
    end
    tests++;
    if (dly < TMO || dly > TMO + FLT + 12) begin
      fails++;
      $display("FAIL timeout_delay got=%0d exp=%0d..%0d", dly, TMO, TMO + FLT + 12);
    end
  endtask

  task automatic test_ignore_start();
    int stray;
    send_start(8'hED);
    fork
      device(11, 1'b1, 1'b0);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_done();
    tests++;
    if (rx_vec !== model(8'hED) || r_ae !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy got=%b ae=%b exp=%b ae=0", rx_vec, r_ae, model(8'hED));
    end
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    stray = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy || ps2_clk_oe) stray++;
      @(negedge clk);
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL ignore_done got=%0d exp=0", stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    run_xfer(a, 11, 1'b1, 1'b0);
    run_xfer(b, 11, 1'b1, 1'b0);
    tests++;
    if (rx_vec !== model(b) || r_inh !== INH || r_ae !== 1'b0) begin
      fails++;
      $display("FAIL b2b got=%b inh=%0d ae=%b exp=%b inh=%0d ae=0",
               rx_vec, r_inh, r_ae, model(b), INH);
    end
  endtask

  task automatic test_reset_mid();
    send_start(8'($urandom));
    device(5, 1'b0, 1'b0);
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset got=%b exp=000", {ps2_clk_oe, ps2_data_oe, busy});
    end
    repeat (5) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    run_xfer(8'hF4, 11, 1'b1, 1'b0);
    tests++;
    if (rx_vec !== model(8'hF4) || r_ae !== 1'b0 || r_inh !== INH) begin
      fails++;
      $display("FAIL post_reset got=%b ae=%b inh=%0d exp=%b ae=0 inh=%0d",
               rx_vec, r_ae, r_inh, model(8'hF4), INH);
    end
  endtask

  task automatic test_idle_traffic();
    int seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      dev_clk = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (busy || done || ps2_clk_oe || ps2_data_oe) seen++;
      end
      dev_clk = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (busy || done || ps2_clk_oe || ps2_data_oe) seen++;
      end
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL idle_traffic got=%0d exp=0", seen);
    end
  endtask

`ifdef PS2_TX_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [7:0] b;
    b = 8'($urandom);
    run_xfer(b, 11, 1'b1, 1'b0 == 1'b0);
    tests++;
    if (rx_vec !== model(b) || r_ae !== 1'b0) begin
      fails++;
      $display("FAIL glitch got=%b ae=%b exp=%b ae=0", rx_vec, r_ae, model(b));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_no_ack();
    test_timeout();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_idle_traffic();
`ifdef PS2_TX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
